deser_in: RTL and testbench

- Receive side of the 9-bit K/data serial link.
- Recovers word alignment from the COMMA K-code, which is 9'h13C (K=1, 8'h3C).
- Reassembles each 3-byte packet (COMMA, D0, D1, D2, COMMA ...) into a 32-bit word and flags protocol errors.
- Sits behind the link input pin/sampler and feeds the payload consumer with a valid pulse per packet.

---
 rtl/serdes_pkg.sv | 24 ++
 rtl/deser_in_if.sv | 43 ++++
 rtl/deser_in_rx_serial.sv | 36 +++
 rtl/deser_in.sv | 165 ++++++++++++++++
 tb/tb_deser_in.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/serdes_pkg.sv
// Shared definitions for the 9-bit K/data serial link, used by both the
// transmit and receive sides.
package serdes_pkg;

    localparam int WORD_W    = 9;
    localparam int KFLAG_BIT = 8;
    localparam int PKT_BYTES = 3;

    localparam logic [WORD_W-1:0] COMMA_WORD = 9'h13C;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_ALIGN,
        ST_IDLE,
        ST_B1,
        ST_B2,
        ST_TAIL
    } state_t;

    function automatic logic is_kcode(input logic [WORD_W-1:0] word);
        return word[KFLAG_BIT];
    endfunction

endpackage

// File: rtl/deser_in_if.sv
// Link-side and payload-side signals of the deserializer.
// DESER_ERR_CNT_EN adds the error counter output and its clear input.
interface deser_in_if;
    import serdes_pkg::*;

    logic        data_i;
    logic        bit_vld_i;
    logic [31:0] data_o;
    logic        valid_o;
    logic        locked_o;
    logic        err_o;
`ifdef DESER_ERR_CNT_EN
    logic [15:0] err_cnt_o;
    logic        err_clr_i;
`endif

    modport slave (
        input  data_i,
        input  bit_vld_i,
`ifdef DESER_ERR_CNT_EN
        input  err_clr_i,
        output err_cnt_o,
`endif
        output data_o,
        output valid_o,
        output locked_o,
        output err_o
    );

    modport master (
        output data_i,
        output bit_vld_i,
`ifdef DESER_ERR_CNT_EN
        output err_clr_i,
        input  err_cnt_o,
`endif
        input  data_o,
        input  valid_o,
        input  locked_o,
        input  err_o
    );

endinterface

// File: rtl/deser_in_rx_serial.sv
// Receive shifter: LSB-first 9-bit shift register plus word bit counter.
// In hunt mode every strobe presents a sliding-window word.
module rx_serial
    import serdes_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              data_i,
    input  logic              bit_vld_i,
    input  logic              hunt_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_vld_o
);

    localparam logic [3:0] LAST_BIT = 4'(WORD_W - 1);

    logic [WORD_W-1:0] sreg_q;
    logic [3:0]        bit_cnt_q;
    logic              word_end;

    // The word is presented in the strobe cycle itself so the FSM can react on the same edge.
    assign word_o     = {data_i, sreg_q[WORD_W-1:1]};
    assign word_end   = hunt_i || (bit_cnt_q == LAST_BIT);
    assign word_vld_o = bit_vld_i && word_end;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sreg_q    <= '0;
            bit_cnt_q <= '0;
        end else if (bit_vld_i) begin
            sreg_q    <= word_o;
            bit_cnt_q <= word_end ? 4'd0 : bit_cnt_q + 4'd1;
        end
    end

endmodule

// File: rtl/deser_in.sv
// Receive side of the 9-bit K/data link: comma alignment, packet assembly, errors.
// DESER_ERR_CNT_EN adds a saturating error counter with synchronous clear.
module deser_in
    import serdes_pkg::*;
#(
    parameter int         LOCK_CNT = 2,
    parameter logic [7:0] COMMA    = COMMA_WORD[7:0]
) (
    input logic       clk_i,
    input logic       rst_ni,
    deser_in_if.slave link
);

    localparam logic [WORD_W-1:0] COMMA_W  = {1'b1, COMMA};
    localparam logic [2:0]        LOCK_TGT = 3'(LOCK_CNT);

    state_t                       state_q, state_n;
    logic [2:0]                   comma_cnt_q, comma_cnt_n;
    logic [PKT_BYTES-2:0][7:0]    pkt_q, pkt_n;
    logic [31:0]                  data_q, data_n;
    logic                         valid_q, valid_n;
    logic                         locked_q, locked_n;
    logic                         err_q, err_n;

    logic [WORD_W-1:0]            word;
    logic                         word_vld;
    logic                         is_comma;
    logic                         is_k;

    rx_serial u_rx_serial (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .data_i     (link.data_i),
        .bit_vld_i  (link.bit_vld_i),
        .hunt_i     (state_q == ST_HUNT),
        .word_o     (word),
        .word_vld_o (word_vld)
    );

    assign is_comma = (word == COMMA_W);
    assign is_k     = is_kcode(word);

    always_comb begin
        state_n     = state_q;
        comma_cnt_n = comma_cnt_q;
        pkt_n       = pkt_q;
        data_n      = data_q;
        valid_n     = 1'b0;
        locked_n    = locked_q;
        err_n       = 1'b0;

        if (word_vld) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (is_comma) begin
                        comma_cnt_n = 3'd1;
                        if (LOCK_TGT == 3'd1) begin
                            locked_n = 1'b1;
                            state_n  = ST_IDLE;
                        end else begin
                            state_n  = ST_ALIGN;
                        end
                    end
                end
                // Losing alignment before lock is silent; only a locked link reports errors.
                ST_ALIGN: begin
                    if (is_comma) begin
                        comma_cnt_n = comma_cnt_q + 3'd1;
                        if (comma_cnt_q + 3'd1 == LOCK_TGT) begin
                            locked_n = 1'b1;
                            state_n  = ST_IDLE;
                        end
                    end else begin
                        comma_cnt_n = '0;
                        state_n     = ST_HUNT;
                    end
                end
                ST_IDLE: begin
                    if (!is_k) begin
                        pkt_n[0] = word[7:0];
                        state_n  = ST_B1;
                    end else if (!is_comma) begin
                        err_n = 1'b1;
                    end
                end
                ST_B1: begin
                    if (!is_k) begin
                        pkt_n[1] = word[7:0];
                        state_n  = ST_B2;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                ST_B2: begin
                    if (!is_k) begin
                        data_n  = {8'h00, word[7:0], pkt_q[1], pkt_q[0]};
                        valid_n = 1'b1;
                        state_n = ST_TAIL;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                ST_TAIL: begin
                    if (is_comma) begin
                        state_n = ST_IDLE;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                default: begin
                    state_n = ST_HUNT;
                end
            endcase

            if (err_n) begin
                locked_n    = 1'b0;
                comma_cnt_n = '0;
                state_n     = ST_HUNT;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_HUNT;
            comma_cnt_q <= '0;
            pkt_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_n;
            comma_cnt_q <= comma_cnt_n;
            pkt_q       <= pkt_n;
            data_q      <= data_n;
            valid_q     <= valid_n;
            locked_q    <= locked_n;
            err_q       <= err_n;
        end
    end

    assign link.data_o   = data_q;
    assign link.valid_o  = valid_q;
    assign link.locked_o = locked_q;
    assign link.err_o    = err_q;

`ifdef DESER_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    // A clear coinciding with a new error leaves that error counted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else if (link.err_clr_i) begin
            err_cnt_q <= {15'd0, err_n};
        end else if (err_n && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign link.err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_deser_in.sv
// Directed self-checking bench for deser_in (LOCK_CNT=2).
// The error-counter checks run only when DESER_ERR_CNT_EN is defined.
module tb_deser_in;
    import serdes_pkg::*;

    localparam logic [8:0] K_COMMA = 9'h13C;
    localparam logic [8:0] K_BAD   = 9'h1F7;

    logic clk_i;
    logic rst_ni;

    int checks;
    int errors;
    int valid_pulses;
    int err_pulses;
    int both_pulses;

    deser_in_if link ();

    deser_in dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .link   (link.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk_i) begin
        if (link.valid_o) valid_pulses++;
        if (link.err_o) err_pulses++;
        if (link.valid_o && link.err_o) both_pulses++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Shifts out the low nbits of a word, LSB first, with gap idle cycles after each strobe.
    task automatic applyStimulus(input logic [8:0] word, input int gap, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            link.data_i    = word[i];
            link.bit_vld_i = 1'b1;
            @(posedge clk_i);
            #1;
            link.bit_vld_i = 1'b0;
            repeat (gap) begin
                @(posedge clk_i);
                #1;
            end
        end
    endtask

    task automatic sendWord(input logic [8:0] word);
        applyStimulus(word, 0, 9);
    endtask

    task automatic applyReset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        valid_pulses = 0;
        err_pulses   = 0;
        both_pulses  = 0;
        rst_ni         = 1'b0;
        link.data_i    = 1'b0;
        link.bit_vld_i = 1'b0;
`ifdef DESER_ERR_CNT_EN
        link.err_clr_i = 1'b0;
`endif
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("rst_data", link.data_o, 32'h0);
        checkOutput("rst_valid", {31'd0, link.valid_o}, 32'd0);
        checkOutput("rst_locked", {31'd0, link.locked_o}, 32'd0);
        checkOutput("rst_err", {31'd0, link.err_o}, 32'd0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Lock after the second aligned comma
        sendWord(K_COMMA);
        checkOutput("lock_c1", {31'd0, link.locked_o}, 32'd0);
        sendWord(K_COMMA);
        checkOutput("lock_c2", {31'd0, link.locked_o}, 32'd1);
        sendWord(K_COMMA);
        checkOutput("lock_c3", {31'd0, link.locked_o}, 32'd1);
        checkOutput("lock_novalid", valid_pulses, 0);

        // First packet, valid one cycle after the last D2 strobe
        sendWord(9'h0A1);
        sendWord(9'h0B2);
        checkOutput("pkt1_pre_valid", {31'd0, link.valid_o}, 32'd0);
        sendWord(9'h0C3);
        checkOutput("pkt1_valid", {31'd0, link.valid_o}, 32'd1);
        checkOutput("pkt1_data", link.data_o, 32'h00C3B2A1);
        sendWord(K_COMMA);
        checkOutput("pkt1_valid_drop", {31'd0, link.valid_o}, 32'd0);
        checkOutput("pkt1_hold", link.data_o, 32'h00C3B2A1);
        checkOutput("pkt1_pulses", valid_pulses, 1);

        // Garbage prefix and 1-in-3 strobes
        applyReset();
        applyStimulus(9'h00D, 2, 4);
        applyStimulus(K_COMMA, 2, 9);
        checkOutput("gap_c1", {31'd0, link.locked_o}, 32'd0);
        applyStimulus(K_COMMA, 2, 9);
        checkOutput("gap_c2", {31'd0, link.locked_o}, 32'd1);
        applyStimulus(9'h001, 2, 9);
        applyStimulus(9'h002, 2, 9);
        applyStimulus(9'h003, 2, 9);
        checkOutput("gap_data", link.data_o, 32'h00030201);
        applyStimulus(K_COMMA, 2, 9);
        checkOutput("gap_pulses", valid_pulses, 2);

        // K-code inside a packet
        sendWord(9'h011);
        sendWord(K_BAD);
        checkOutput("err_pulse", {31'd0, link.err_o}, 32'd1);
        checkOutput("err_unlock", {31'd0, link.locked_o}, 32'd0);
        checkOutput("err_data_hold", link.data_o, 32'h00030201);
        sendWord(K_COMMA);
        checkOutput("err_pulse_drop", {31'd0, link.err_o}, 32'd0);
        checkOutput("relock_c1", {31'd0, link.locked_o}, 32'd0);
        sendWord(K_COMMA);
        checkOutput("relock_c2", {31'd0, link.locked_o}, 32'd1);
        checkOutput("err_novalid", valid_pulses, 2);
        checkOutput("err_pulses", err_pulses, 1);

        // Back-to-back packets with one comma between
        sendWord(9'h010);
        sendWord(9'h020);
        sendWord(9'h030);
        checkOutput("b2b_data1", link.data_o, 32'h00302010);
        sendWord(K_COMMA);
        sendWord(9'h040);
        sendWord(9'h050);
        sendWord(9'h060);
        checkOutput("b2b_valid2", {31'd0, link.valid_o}, 32'd1);
        checkOutput("b2b_data2", link.data_o, 32'h00605040);
        sendWord(K_COMMA);
        checkOutput("b2b_pulses", valid_pulses, 4);

        // Reset in the middle of D2
        sendWord(9'h077);
        sendWord(9'h088);
        applyStimulus(9'h099, 0, 4);
        rst_ni = 1'b0;
        #1;
        checkOutput("midrst_data", link.data_o, 32'h0);
        checkOutput("midrst_locked", {31'd0, link.locked_o}, 32'd0);
        checkOutput("midrst_valid", {31'd0, link.valid_o}, 32'd0);
        checkOutput("midrst_err", {31'd0, link.err_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        applyStimulus(9'h1FF, 0, 5);
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("midrst_novalid", valid_pulses, 4);

`ifdef DESER_ERR_CNT_EN
        applyReset();
        checkOutput("cnt_rst", {16'd0, link.err_cnt_o}, 32'd0);
        sendWord(K_COMMA);
        sendWord(K_COMMA);
        for (int e = 0; e < 3; e++) begin
            sendWord(K_BAD);
            sendWord(K_COMMA);
            sendWord(K_COMMA);
        end
        checkOutput("cnt_three", {16'd0, link.err_cnt_o}, 32'd3);
        checkOutput("cnt_relock", {31'd0, link.locked_o}, 32'd1);
        link.err_clr_i = 1'b1;
        sendWord(K_BAD);
        link.err_clr_i = 1'b0;
        checkOutput("cnt_clr_err", {31'd0, link.err_o}, 32'd1);
        checkOutput("cnt_clr_same", {16'd0, link.err_cnt_o}, 32'd1);
        checkOutput("cnt_err_pulses", err_pulses, 5);
`endif

        checkOutput("never_both", both_pulses, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
